// File: rtl/l2_port_arbiter_pkg.sv
// Shared definitions for the L2 port arbiter: state encoding, line width
// and requester-count limits used across the L1/L2 slice.
package l2_port_arbiter_pkg;

    localparam int L1_LINE_WIDTH = 512;
    localparam int ARB_MAX_REQ   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RESP    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_select.sv
// Combinational round-robin pick: first active requester at or after rr_ptr,
// wrapping modulo NUM_REQ. Returns the one-hot winner and its index.
module l2_port_arbiter_rr_select
    import l2_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_MAX_REQ,
    parameter int IDX_W   = arb_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               found
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            cand = sum[IDX_W-1:0];
            if (!found && active[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L1-facing L2 port between NUM_REQ
// private L1 caches; one captured line transaction in flight at a time.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = L1_LINE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ-1:0]        req_wr,
    output logic [LINE_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         l2_addr,
    output logic [LINE_W-1:0]         l2_wdata,
    output logic                      l2_rd,
    output logic                      l2_wr,
    input  logic [LINE_W-1:0]         l2_rdata,
    input  logic                      l2_ready,
    output logic [NUM_REQ-1:0]        grant
);

    localparam int               IDX_W    = arb_idx_w(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx_q;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [LINE_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*LINE_W +: LINE_W];
    end

    // A requester with both rd and wr raised is served as a write.
    assign active = req_rd | req_wr;

    l2_port_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .active     (active),
        .rr_ptr     (rr_ptr),
        .winner     (sel_onehot),
        .winner_idx (sel_idx),
        .found      (sel_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            win_idx_q <= '0;
            grant     <= '0;
            req_ready <= '0;
            req_rdata <= '0;
            l2_addr   <= '0;
            l2_wdata  <= '0;
            l2_rd     <= 1'b0;
            l2_wr     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (sel_found) begin
                        l2_addr   <= addr_arr[sel_idx];
                        l2_wdata  <= wdata_arr[sel_idx];
                        l2_wr     <= req_wr[sel_idx];
                        l2_rd     <= ~req_wr[sel_idx];
                        grant     <= sel_onehot;
                        win_idx_q <= sel_idx;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (l2_ready) begin
                        if (l2_rd) begin
                            req_rdata <= l2_rdata;
                        end
                        l2_rd     <= 1'b0;
                        l2_wr     <= 1'b0;
                        rr_ptr    <= (win_idx_q == LAST_IDX) ? '0 : win_idx_q + IDX_W'(1);
                        req_ready <= grant;
                        state     <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    req_ready <= '0;
                    grant     <= '0;
                    state     <= ARB_RELEASE;
                end
                // One dead cycle lets the winner drop rd/wr before re-arbitration.
                ARB_RELEASE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: expected transactions are queued when
// requests are driven and checked at L2 issue and at requester completion.
`timescale 1ns/1ps
module tb_l2_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 512;
    localparam int LW      = 512;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ-1:0]        req_wr;
    logic [LINE_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         l2_addr;
    logic [LINE_W-1:0]         l2_wdata;
    logic                      l2_rd;
    logic                      l2_wr;
    logic [LINE_W-1:0]         l2_rdata;
    logic                      l2_ready;
    logic [NUM_REQ-1:0]        grant;

    always #5 clk = ~clk;

    l2_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_rdata (req_rdata),
        .req_ready (req_ready),
        .l2_addr   (l2_addr),
        .l2_wdata  (l2_wdata),
        .l2_rd     (l2_rd),
        .l2_wr     (l2_wr),
        .l2_rdata  (l2_rdata),
        .l2_ready  (l2_ready),
        .grant     (grant)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wr;
        logic [511:0] wdata;
        int          lat;
        bit          gap;
        bit          drop;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp   = 0;
    int           n_err   = 0;
    int           n_done  = 0;
    int           cyc     = 0;
    int           l2_lat  = 1;
    bit           stray   = 1'b0;
    logic [511:0] model_rdata = '0;

    function automatic logic [511:0] line_pat(input logic [31:0] a);
        return {16{a ^ 32'hA5A5_A5A5}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] a, input logic wr,
                            input logic [511:0] wd, input int lat, input bit gap, input bit drop);
        exp_t e;
        e.idx = idx; e.addr = a; e.wr = wr; e.wdata = wd;
        e.lat = lat; e.gap = gap; e.drop = drop;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [511:0] wd);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*LINE_W +: LINE_W] = wd;
        req_rd[i] = rd;
        req_wr[i] = wr;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_l2_rd"},     LW'(l2_rd),     '0);
        chk({tag, "_l2_wr"},     LW'(l2_wr),     '0);
        chk({tag, "_grant"},     LW'(grant),     '0);
        chk({tag, "_req_ready"}, LW'(req_ready), '0);
        chk({tag, "_req_rdata"}, req_rdata,      '0);
        chk({tag, "_l2_addr"},   LW'(l2_addr),   '0);
        chk({tag, "_l2_wdata"},  l2_wdata,       '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        req_rd = '0;
        req_wr = '0;
        rst    = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_count", LW'(n_done), LW'(target));
    endtask

    // L2 model: answers each issued line after l2_lat cycles with a one-cycle ready.
    task automatic l2_model();
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                l2_ready = 1'b0;
                cnt      = 0;
            end else if (l2_ready) begin
                l2_ready = 1'b0;
                cnt      = 0;
            end else if (stray) begin
                l2_ready = 1'b1;
                l2_rdata = '1;
            end else if (l2_rd || l2_wr) begin
                cnt++;
                if (cnt >= l2_lat) begin
                    l2_ready = 1'b1;
                    l2_rdata = line_pat(l2_addr);
                end
            end
        end
    endtask

    task automatic monitor();
        bit         prev_busy  = 1'b0;
        logic [1:0] prev_ready = '0;
        int         hold       = 0;
        int         rdy_cyc    = -100;
        exp_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_busy   = 1'b0;
                prev_ready  = '0;
                hold        = 0;
                model_rdata = '0;
                continue;
            end
            if ((l2_rd || l2_wr) && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", LW'(1), LW'(0));
                end else begin
                    e = exp_q[0];
                    chk("issue_grant", LW'(grant),   LW'(1 << e.idx));
                    chk("issue_addr",  LW'(l2_addr), LW'(e.addr));
                    chk("issue_wr",    LW'(l2_wr),   LW'(e.wr));
                    chk("issue_rd",    LW'(l2_rd),   LW'(!e.wr));
                    if (e.wr) chk("issue_wdata", l2_wdata, e.wdata);
                    if (e.gap) chk("issue_gap", LW'(cyc - rdy_cyc), LW'(3));
                end
            end
            if (l2_rd || l2_wr) hold++;
            if (req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", LW'(req_ready), '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_ready", LW'(req_ready), LW'(1 << e.idx));
                    chk("resp_grant", LW'(grant),     LW'(1 << e.idx));
                    chk("resp_hold",  LW'(hold),      LW'(e.lat));
                    if (!e.wr) model_rdata = line_pat(e.addr);
                    chk("resp_rdata", req_rdata, model_rdata);
                    if (e.wr) chk("resp_wdata_held", l2_wdata, e.wdata);
                    if (e.drop) begin
                        req_rd[e.idx] = 1'b0;
                        req_wr[e.idx] = 1'b0;
                    end
                    n_done++;
                end
                rdy_cyc = cyc;
                hold    = 0;
            end else if (prev_ready != '0) begin
                chk("ready_pulse",   LW'(req_ready), '0);
                chk("release_grant", LW'(grant),     '0);
            end
            prev_busy  = l2_rd || l2_wr;
            prev_ready = req_ready;
        end
    endtask

    initial begin
        int base;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;
        req_wr    = '0;
        l2_ready  = 1'b0;
        l2_rdata  = '0;
        fork
            l2_model();
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("por");
        #1 rst = 1'b0;

        // Single read with a slow L2.
        l2_lat = 10;
        base = n_done;
        push_exp(0, 32'h1000, 1'b0, '0, 10, 1'b0, 1'b1);
        @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 32'h1000, {16{32'h0BAD_F00D}});
        wait_done(base + 1, 60);

        // Write-back whose source line changes after capture.
        l2_lat = 4;
        base = n_done;
        push_exp(1, 32'h3000, 1'b1, {16{32'hDEAD_BEEF}}, 4, 1'b0, 1'b1);
        @(posedge clk); #1 set_req(1, 1'b0, 1'b1, 32'h3000, {16{32'hDEAD_BEEF}});
        repeat (2) @(posedge clk);
        #1 req_wdata[LINE_W +: LINE_W] = {16{32'h1234_5678}};
        wait_done(base + 1, 40);

        // rd and wr together are served as a write.
        l2_lat = 2;
        base = n_done;
        push_exp(0, 32'h4000, 1'b1, {16{32'hC0FF_EE00}}, 2, 1'b0, 1'b1);
        @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 32'h4000, {16{32'hC0FF_EE00}});
        wait_done(base + 1, 40);

        // Simultaneous reads after reset: 0 first, then 1.
        do_reset();
        l2_lat = 3;
        base = n_done;
        push_exp(0, 32'h1000, 1'b0, '0, 3, 1'b0, 1'b1);
        push_exp(1, 32'h2000, 1'b0, '0, 3, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h1000, '0);
        set_req(1, 1'b1, 1'b0, 32'h2000, '0);
        wait_done(base + 2, 60);

        // Back-to-back fairness over 8 transactions.
        do_reset();
        l2_lat = 1;
        base = n_done;
        for (int k = 0; k < 8; k++) begin
            push_exp(k % 2, (k % 2 == 0) ? 32'h1100 : 32'h2200, 1'b0, '0, 1, k > 0, k >= 6);
        end
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h1100, '0);
        set_req(1, 1'b1, 1'b0, 32'h2200, '0);
        wait_done(base + 8, 200);

        // Reset in the middle of an issue restores requester 0 priority.
        do_reset();
        l2_lat = 1;
        base = n_done;
        push_exp(0, 32'h5000, 1'b0, '0, 1, 1'b0, 1'b1);
        @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 32'h5000, '0);
        wait_done(base + 1, 40);
        l2_lat = 20;
        push_exp(1, 32'h6000, 1'b0, '0, 20, 1'b0, 1'b1);
        @(posedge clk); #1 set_req(1, 1'b1, 1'b0, 32'h6000, '0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_issue");
        req_rd = '0;
        req_wr = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        l2_lat = 2;
        base = n_done;
        push_exp(0, 32'h7000, 1'b0, '0, 2, 1'b0, 1'b1);
        push_exp(1, 32'h8000, 1'b0, '0, 2, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h7000, '0);
        set_req(1, 1'b1, 1'b0, 32'h8000, '0);
        wait_done(base + 2, 60);

        // Stray L2 ready while idle must not complete anything.
        repeat (4) @(posedge clk);
        #1 stray = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stray_ready", LW'(req_ready), '0);
            chk("stray_rd",    LW'(l2_rd),     '0);
        end
        chk("queue_empty", LW'(exp_q.size()), '0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
